// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared constants for blocks consuming JTAG user-register data in the system
// clock domain: ADC channel count, JTAG mask default, settle window length,
// active-count width, and the mask-apply FSM state encoding.
// -----------------------------------------------------------------------------
package jtag_pkg;

  localparam int               NCH      = 12;
  localparam logic [NCH-1:0]   DEF_MASK = 12'hFFF;
  localparam int               SETTLE   = 4;
  localparam int               CNTW     = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2,
    S_APPLY  = 2'd3
  } state_t;

endpackage

// File: rtl/tgl_sync.sv
// -----------------------------------------------------------------------------
// tgl_sync
// Generic 3-flop toggle-to-pulse synchronizer. Each level change on i_tgl
// (foreign clock domain) produces exactly one i_clk-cycle pulse on o_pulse.
//   i_clk    in   destination clock
//   i_rst_n  in   asynchronous active-low reset (flops clear to 0)
//   i_tgl    in   toggle from the source domain
//   o_pulse  out  one-cycle pulse per source toggle
// Because the flops clear to 0, a toggle line already high at reset release
// yields one pulse.
// -----------------------------------------------------------------------------
module tgl_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tgl,
  output logic o_pulse
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift chain.
      r_sync <= {r_sync[1:0], i_tgl};
    end
  end

  // Stage 3 is the reference; stages 1-2 absorb metastability.
  assign o_pulse = r_sync[1] ^ r_sync[2];

endmodule

// File: rtl/adc_mask_apply.sv
// -----------------------------------------------------------------------------
// adc_mask_apply
// Moves the JTAG-written ADC channel mask into the CLK domain and applies it
// only between readout frames.
//   CLK         in   system clock
//   RST_N       in   asynchronous active-low reset
//   UPD_TGL     in   toggles once per JTAG mask update (TCK domain)
//   MASK_IN     in   quasi-static mask from the JTAG register (TCK domain)
//   FRAME_BUSY  in   high while a readout frame is in progress
//   MASK_OUT    out  applied mask, 1 = channel enabled
//   N_ACTIVE    out  popcount(MASK_OUT), registered alongside it
//   MASK_CHG    out  one-cycle pulse on the cycle MASK_OUT changes
//   PENDING     out  high from detected update until the mask is applied
// Flow: IDLE -> SETTLE (MASK_IN held SETTLE cycles) -> WAIT (for frame gap)
//       -> APPLY (one cycle). A new update in SETTLE/WAIT restarts the window.
// -----------------------------------------------------------------------------
module adc_mask_apply #(
  parameter int             NCH      = jtag_pkg::NCH,
  parameter logic [NCH-1:0] DEF_MASK = jtag_pkg::DEF_MASK,
  parameter int             SETTLE   = jtag_pkg::SETTLE,
  parameter int             CNTW     = jtag_pkg::CNTW
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            UPD_TGL,
  input  logic [NCH-1:0]  MASK_IN,
  input  logic            FRAME_BUSY,
  output logic [NCH-1:0]  MASK_OUT,
  output logic [CNTW-1:0] N_ACTIVE,
  output logic            MASK_CHG,
  output logic            PENDING
);

  import jtag_pkg::*;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  function automatic logic [CNTW-1:0] popcount(input logic [NCH-1:0] m);
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) n = n + CNTW'(m[i]);
    return n;
  endfunction

  logic            w_upd_p;
  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [NCH-1:0]  r_hold;
  logic [NCH-1:0]  r_shadow;
  logic [NCH-1:0]  r_mask_out;
  logic [CNTW-1:0] r_n_active;
  logic            r_mask_chg;
  logic            r_pending;

  tgl_sync u_upd_sync (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_tgl   (UPD_TGL),
    .o_pulse (w_upd_p)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      // NOTE: the capture registers are reset too; they are few flops and a
      // known value keeps an APPLY after any odd path from exposing X.
      r_hold     <= DEF_MASK;
      r_shadow   <= DEF_MASK;
      r_mask_out <= DEF_MASK;
      r_n_active <= popcount(DEF_MASK);
      r_mask_chg <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_mask_chg <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pending <= 1'b0;
          if (w_upd_p) begin
            r_state   <= S_SETTLE;
            r_cnt     <= CNT_LOAD;
            r_pending <= 1'b1;
          end
        end
        S_SETTLE: begin
          // A fresh update outranks expiry: MASK_IN may be moving again.
          if (w_upd_p) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt == 4'd0) begin
            r_hold  <= MASK_IN;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WAIT: begin
          r_shadow <= r_hold;
          if (w_upd_p) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_LOAD;
          end else if (!FRAME_BUSY) begin
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          // Committed in WAIT; FRAME_BUSY is deliberately not looked at here.
          r_mask_out <= r_shadow;
          r_n_active <= popcount(r_shadow);
          r_mask_chg <= (r_shadow != r_mask_out);
          if (w_upd_p) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign MASK_OUT = r_mask_out;
  assign N_ACTIVE = r_n_active;
  assign MASK_CHG = r_mask_chg;
  assign PENDING  = r_pending;

endmodule

// File: tb/tb_adc_mask_apply.sv
// -----------------------------------------------------------------------------
// tb_adc_mask_apply
// Directed scenarios for adc_mask_apply with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adc_mask_apply;

  logic        CLK;
  logic        RST_N;
  logic        UPD_TGL;
  logic [11:0] MASK_IN;
  logic        FRAME_BUSY;
  logic [11:0] MASK_OUT;
  logic [3:0]  N_ACTIVE;
  logic        MASK_CHG;
  logic        PENDING;

  int n_pass  = 0;
  int n_total = 0;

  adc_mask_apply dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .UPD_TGL    (UPD_TGL),
    .MASK_IN    (MASK_IN),
    .FRAME_BUSY (FRAME_BUSY),
    .MASK_OUT   (MASK_OUT),
    .N_ACTIVE   (N_ACTIVE),
    .MASK_CHG   (MASK_CHG),
    .PENDING    (PENDING)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N      = 1'b0;
    UPD_TGL    = 1'b0;
    FRAME_BUSY = 1'b0;
    cycles(2);
    RST_N = 1'b1;
    cycles(2);
  endtask

  task automatic test_reset();
    int bad;
    RST_N = 1'b0; UPD_TGL = 1'b0; FRAME_BUSY = 1'b0; MASK_IN = 12'h000;
    cycles(3);
    n_total++;
    if (MASK_OUT !== 12'hFFF) $display("FAIL reset_mask_out got %h exp fff", MASK_OUT);
    else n_pass++;
    n_total++;
    if (N_ACTIVE !== 4'd12) $display("FAIL reset_n_active got %0d exp 12", N_ACTIVE);
    else n_pass++;
    n_total++;
    if (PENDING !== 1'b0 || MASK_CHG !== 1'b0)
      $display("FAIL reset_flags got pend=%b chg=%b exp 0/0", PENDING, MASK_CHG);
    else n_pass++;
    RST_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (MASK_OUT !== 12'hFFF || MASK_CHG !== 1'b0 || PENDING !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_stable got %0d bad cycles exp 0", bad);
    else n_pass++;
  endtask

  task automatic test_basic_update();
    int   t_pend, t_chg, n_chg;
    logic pend_at_chg, pend_before_chg, last_pend;
    do_reset();
    t_pend = -1; t_chg = -1; n_chg = 0;
    pend_at_chg = 1'b1; pend_before_chg = 1'b0; last_pend = 1'b0;
    MASK_IN = 12'h0F3;
    UPD_TGL = ~UPD_TGL;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (PENDING === 1'b1 && t_pend < 0) t_pend = i;
      if (MASK_CHG === 1'b1) begin
        n_chg++;
        if (t_chg < 0) begin
          t_chg = i; pend_at_chg = PENDING; pend_before_chg = last_pend;
        end
      end
      last_pend = PENDING;
    end
    n_total++;
    if (t_pend < 2 || t_pend > 4) $display("FAIL basic_pend_rise got %0d exp 3+-1", t_pend);
    else n_pass++;
    n_total++;
    if (t_chg < 8 || t_chg > 10) $display("FAIL basic_latency got %0d exp 9+-1", t_chg);
    else n_pass++;
    n_total++;
    if (n_chg != 1) $display("FAIL basic_chg_count got %0d exp 1", n_chg);
    else n_pass++;
    n_total++;
    if (pend_at_chg !== 1'b0 || pend_before_chg !== 1'b1)
      $display("FAIL basic_pend_fall got at=%b before=%b exp 0/1", pend_at_chg, pend_before_chg);
    else n_pass++;
    n_total++;
    if (MASK_OUT !== 12'h0F3 || N_ACTIVE !== 4'd6)
      $display("FAIL basic_value got %h/%0d exp 0f3/6", MASK_OUT, N_ACTIVE);
    else n_pass++;
  endtask

  task automatic test_busy_deferral();
    int bad;
    do_reset();
    FRAME_BUSY = 1'b1;
    MASK_IN    = 12'h801;
    UPD_TGL    = ~UPD_TGL;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (MASK_OUT !== 12'hFFF || MASK_CHG !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL busy_hold got %0d bad cycles exp 0", bad);
    else n_pass++;
    n_total++;
    if (PENDING !== 1'b1) $display("FAIL busy_pending got %b exp 1", PENDING);
    else n_pass++;
    FRAME_BUSY = 1'b0;
    @(negedge CLK);
    n_total++;
    if (MASK_OUT !== 12'hFFF) $display("FAIL busy_one_cycle got %h exp fff", MASK_OUT);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (MASK_OUT !== 12'h801 || N_ACTIVE !== 4'd2 || MASK_CHG !== 1'b1)
      $display("FAIL busy_apply got %h/%0d chg=%b exp 801/2/1", MASK_OUT, N_ACTIVE, MASK_CHG);
    else n_pass++;
  endtask

  task automatic test_restart();
    int n_chg, n_bad;
    do_reset();
    n_chg = 0; n_bad = 0;
    MASK_IN = 12'h00F;
    UPD_TGL = ~UPD_TGL;
    // SETTLE is entered on the 3rd edge; re-toggle two cycles into it.
    cycles(4);
    MASK_IN = 12'hF00;
    UPD_TGL = ~UPD_TGL;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (MASK_CHG === 1'b1) n_chg++;
      if (MASK_OUT === 12'h00F) n_bad++;
    end
    n_total++;
    if (n_bad != 0) $display("FAIL restart_stale got %0d cycles of 00f exp 0", n_bad);
    else n_pass++;
    n_total++;
    if (n_chg != 1) $display("FAIL restart_chg_count got %0d exp 1", n_chg);
    else n_pass++;
    n_total++;
    if (MASK_OUT !== 12'hF00 || N_ACTIVE !== 4'd4)
      $display("FAIL restart_value got %h/%0d exp f00/4", MASK_OUT, N_ACTIVE);
    else n_pass++;
  endtask

  task automatic test_same_value();
    int n_chg, n_pend;
    do_reset();
    n_chg = 0; n_pend = 0;
    MASK_IN = 12'hFFF;
    UPD_TGL = ~UPD_TGL;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (MASK_CHG === 1'b1) n_chg++;
      if (PENDING === 1'b1) n_pend++;
    end
    n_total++;
    if (n_pend == 0 || PENDING !== 1'b0)
      $display("FAIL same_pending got %0d high cycles, end=%b exp >0, 0", n_pend, PENDING);
    else n_pass++;
    n_total++;
    if (n_chg != 0 || MASK_OUT !== 12'hFFF)
      $display("FAIL same_no_chg got chg=%0d mask=%h exp 0/fff", n_chg, MASK_OUT);
    else n_pass++;
  endtask

  task automatic test_zero_mask();
    do_reset();
    MASK_IN = 12'h000;
    UPD_TGL = ~UPD_TGL;
    cycles(15);
    n_total++;
    if (MASK_OUT !== 12'h000 || N_ACTIVE !== 4'd0)
      $display("FAIL zero_mask got %h/%0d exp 000/0", MASK_OUT, N_ACTIVE);
    else n_pass++;
  endtask

  task automatic test_tgl_high_at_reset();
    int n_chg;
    @(negedge CLK);
    RST_N = 1'b0; FRAME_BUSY = 1'b0;
    UPD_TGL = 1'b1; MASK_IN = 12'h0F0;
    cycles(2);
    RST_N = 1'b1;
    n_chg = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (MASK_CHG === 1'b1) n_chg++;
    end
    n_total++;
    if (MASK_OUT !== 12'h0F0 || N_ACTIVE !== 4'd4 || n_chg != 1)
      $display("FAIL tgl_high_reset got %h/%0d chg=%0d exp 0f0/4/1", MASK_OUT, N_ACTIVE, n_chg);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int n_bad;
    do_reset();
    MASK_IN = 12'h0F3;
    UPD_TGL = ~UPD_TGL;
    cycles(12);
    n_total++;
    if (MASK_OUT !== 12'h0F3) $display("FAIL midrst_setup got %h exp 0f3", MASK_OUT);
    else n_pass++;
    FRAME_BUSY = 1'b1;
    MASK_IN    = 12'h123;
    UPD_TGL    = ~UPD_TGL;
    cycles(12);
    n_total++;
    if (PENDING !== 1'b1 || MASK_OUT !== 12'h0F3)
      $display("FAIL midrst_wait got pend=%b mask=%h exp 1/0f3", PENDING, MASK_OUT);
    else n_pass++;
    #2 RST_N = 1'b0;
    #1;
    n_total++;
    if (MASK_OUT !== 12'hFFF || PENDING !== 1'b0 || N_ACTIVE !== 4'd12)
      $display("FAIL midrst_async got %h pend=%b n=%0d exp fff/0/12", MASK_OUT, PENDING, N_ACTIVE);
    else n_pass++;
    @(negedge CLK);
    RST_N      = 1'b1;
    FRAME_BUSY = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (MASK_OUT !== 12'hFFF || MASK_CHG !== 1'b0 || PENDING !== 1'b0) n_bad++;
    end
    n_total++;
    if (n_bad != 0) $display("FAIL midrst_no_apply got %0d bad cycles exp 0", n_bad);
    else n_pass++;
  endtask

  initial begin
    RST_N = 1'b0; UPD_TGL = 1'b0; FRAME_BUSY = 1'b0; MASK_IN = 12'h000;
    test_reset();
    test_basic_update();
    test_busy_deferral();
    test_restart();
    test_same_value();
    test_zero_mask();
    test_tgl_high_at_reset();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
